// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave.
// Holds the FSM state enum and the frame-length clamp.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } spi_slv_state_t;

   localparam int SPI_MAXLEN_DEF = 16;

   function automatic int clamp_len(input int nb, input int maxlen);
      return (nb == 0 || nb > maxlen) ? maxlen : nb;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input.
// Provides the settled level plus one-clk rise/fall pulses.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic sresetn,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with a one-entry tx buffer.
// All SPI pins are synchronized into the clk domain first.
module spi_slave
   import spi_pkg::*;
#(
   parameter int SPI_MAXLEN  = SPI_MAXLEN_DEF,
   parameter int SYNC_STAGES = 2,
   localparam int LW = $clog2(SPI_MAXLEN) + 1
) (
   input  logic                  clk,
   input  logic                  sresetn,
   input  logic                  SCLK,
   input  logic                  SS_N,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_OE,
   input  logic [LW-1:0]         n_bits,
   input  logic [SPI_MAXLEN-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [SPI_MAXLEN-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  frame_err
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ss_lvl, ss_rise, ss_fall;
   logic mosi_lvl, mosi_unused_rise, mosi_unused_fall;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .sresetn(sresetn), .d(SCLK),
      .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
      .clk(clk), .sresetn(sresetn), .d(SS_N),
      .q(ss_lvl), .rise(ss_rise), .fall(ss_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .sresetn(sresetn), .d(MOSI),
      .q(mosi_lvl), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
   );

   spi_slv_state_t        state_q, state_d;
   logic [LW-1:0]         len_q, len_d, cnt_q, cnt_d;
   logic [SPI_MAXLEN-1:0] txsh_q, txsh_d, rxsh_q, rxsh_d;
   logic [SPI_MAXLEN-1:0] rxd_q, rxd_d, buf_q, buf_d;
   logic                  full_q, full_d, miso_q, miso_d, oe_q, oe_d;
   logic                  rxv_q, rxv_d, und_q, und_d, ferr_q, ferr_d;
   logic [SYNC_STAGES:0]  init_q, init_d;
   logic [SPI_MAXLEN-1:0] len_mask, rx_word, tx_pick;

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < SPI_MAXLEN; i++)
         len_mask[i] = (i < int'(len_q));
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      txsh_d  = txsh_q;
      rxsh_d  = rxsh_q;
      rxd_d   = rxd_q;
      buf_d   = buf_q;
      full_d  = full_q;
      miso_d  = miso_q;
      oe_d    = ~ss_lvl;
      rxv_d   = 1'b0;
      und_d   = 1'b0;
      ferr_d  = 1'b0;
      init_d  = {init_q[SYNC_STAGES-1:0], 1'b1};
      rx_word = {rxsh_q[SPI_MAXLEN-2:0], mosi_lvl};
      tx_pick = txsh_q >> (cnt_q - LW'(1));
      if (tx_valid && !full_q) begin
         buf_d  = tx_data;
         full_d = 1'b1;
      end
      unique case (state_q)
         IDLE: if (ss_fall) begin
            len_d   = LW'(clamp_len(int'(n_bits), SPI_MAXLEN));
            txsh_d  = full_q ? buf_q : '0;
            und_d   = ~full_q;
            // a word handshaken this cycle stays for the next frame
            full_d  = tx_valid & ~full_q;
            cnt_d   = len_d;
            rxsh_d  = '0;
            tx_pick = txsh_d >> (len_d - LW'(1));
            miso_d  = tx_pick[0];
            state_d = SHIFT;
         end
         SHIFT: begin
            if (ss_rise) begin
               ferr_d  = 1'b1;
               miso_d  = 1'b0;
               state_d = IDLE;
            end else if (sclk_rise) begin
               rxsh_d = rx_word;
               cnt_d  = cnt_q - LW'(1);
               if (cnt_q == LW'(1)) begin
                  rxd_d   = rx_word & len_mask;
                  rxv_d   = 1'b1;
                  state_d = DONE;
               end
            end else if (sclk_fall && cnt_q != '0) begin
               miso_d = tx_pick[0];
            end
         end
         DONE: begin
            // wait until the synchronizers reflect the real pin level
            if (ss_lvl && init_q[SYNC_STAGES]) begin
               miso_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = DONE;
      endcase
   end

   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         state_q <= DONE;
         len_q   <= LW'(SPI_MAXLEN);
         cnt_q   <= '0;
         txsh_q  <= '0;
         rxsh_q  <= '0;
         rxd_q   <= '0;
         buf_q   <= '0;
         full_q  <= 1'b0;
         miso_q  <= 1'b0;
         oe_q    <= 1'b0;
         rxv_q   <= 1'b0;
         und_q   <= 1'b0;
         ferr_q  <= 1'b0;
         init_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         txsh_q  <= txsh_d;
         rxsh_q  <= rxsh_d;
         rxd_q   <= rxd_d;
         buf_q   <= buf_d;
         full_q  <= full_d;
         miso_q  <= miso_d;
         oe_q    <= oe_d;
         rxv_q   <= rxv_d;
         und_q   <= und_d;
         ferr_q  <= ferr_d;
         init_q  <= init_d;
      end
   end

   assign MISO        = miso_q;
   assign MISO_OE     = oe_q;
   assign tx_ready    = ~full_q;
   assign rx_data     = rxd_q;
   assign rx_valid    = rxv_q;
   assign tx_underrun = und_q;
   assign frame_err   = ferr_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SPI_MAXLEN, default 16, maximum frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for SCLK, SS_N and MOSI (minimum 2).
REQ-003 clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-004 sresetn  input  1  reset, asynchronous assertion, active-low.
REQ-005 SCLK  input  1  SPI clock from the master, asynchronous to clk.
REQ-006 SS_N  input  1  slave select from the master; a frame is active while it is 0.
REQ-007 MOSI  input  1  serial data from the master.
REQ-008 MISO  output  1  serial data to the master, registered.
REQ-009 MISO_OE  output  1  MISO drive enable; 1 while synchronized SS_N is 0.
REQ-010 n_bits  input  $clog2(SPI_MAXLEN)+1  frame length, sampled at frame start.
REQ-011 tx_data  input  SPI_MAXLEN  word to send, right-aligned.
REQ-012 tx_valid / tx_ready  input / output  1 each  load handshake for the one-entry tx buffer.
REQ-013 rx_data  output  SPI_MAXLEN  last received word, right-aligned, upper bits zero.
REQ-014 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-015 tx_underrun  output  1  one-clk pulse when a frame starts with the tx buffer empty.
REQ-016 frame_err  output  1  one-clk pulse when SS_N rises before n_bits bits are received.

Function
REQ-017 Protocol is SPI mode 0, MSB first: MOSI is sampled on the SCLK rising edge, and MISO changes on the SCLK falling edge; clk frequency is at least 4x SCLK.
REQ-018 SCLK, SS_N and MOSI each pass through SYNC_STAGES flops; edges are detected on the synchronized signals only.
REQ-019 States: IDLE, SHIFT, DONE.
REQ-020 IDLE -> SHIFT on a synchronized SS_N fall:
- latch len = n_bits, clamped to SPI_MAXLEN when the value is 0 or greater than SPI_MAXLEN;
- load tx_shift from the tx buffer, or all-zero plus a tx_underrun pulse if the buffer is empty;
- set bit_cnt = len;
- register MISO = tx_shift[len-1].
REQ-021 In SHIFT, on each synchronized SCLK rise: rx_shift = {rx_shift, MOSI}, then bit_cnt decrements.
REQ-022 In SHIFT, on each synchronized SCLK fall with bit_cnt > 0: MISO = tx_shift[bit_cnt-1].
REQ-023 When bit_cnt reaches 0: on the next clk, rx_data = rx_shift masked to len bits, rx_valid pulses, and the state goes to DONE. Latency from the synchronized final SCLK rise to rx_valid is 1 clk.
REQ-024 DONE ignores SCLK; a synchronized SS_N rise returns the state to IDLE.
REQ-025 A synchronized SS_N rise in SHIFT: frame_err pulses, rx_data and rx_valid are unchanged, and the state returns to IDLE.
REQ-026 tx_ready = 1 iff the tx buffer is empty; tx_valid && tx_ready writes tx_data to the buffer; a frame start empties the buffer.
REQ-027 If a handshake and a frame start occur on the same clk, the frame uses the buffer contents from before that cycle. The new word stays buffered for the next frame, or the frame underruns if the buffer was empty.
REQ-028 tx_valid while tx_ready = 0 has no effect; tx_data is held by the source until the handshake.
REQ-029 MISO is 0 whenever MISO_OE = 0.

Reset
REQ-030 On sresetn = 0: state = DONE, MISO = 0, MISO_OE = 0, tx_ready = 1, rx_data = 0, rx_valid = tx_underrun = frame_err = 0, tx buffer empty, synchronizers flushed to SCLK = 0 and SS_N = 1.
REQ-031 After reset release, DONE waits for synchronized SS_N = 1 before entering IDLE, so a partial frame already in progress is never captured.

Structure
REQ-032 Package spi_pkg holds the state enum spi_slv_state_t, the SPI_MAXLEN default and the length-clamp function.
REQ-033 Sub-module spi_sync (SYNC_STAGES-flop synchronizer with rise/fall pulse outputs) is instantiated for SCLK, SS_N and MOSI; MOSI uses the level output only.

Verification
REQ-034 tx_data = 16'hA5C3, n_bits = 16, master sends 16'h3C5A -> MISO bits 16'hA5C3 MSB first, rx_data = 16'h3C5A, one rx_valid pulse.
REQ-035 n_bits = 5, tx_data = 16'h0013, master sends 5'b10110 -> MISO 1,0,0,1,1; rx_data = 16'h0016.
REQ-036 No tx load before SS_N falls -> tx_underrun pulse, MISO all zero; a tx_valid handshake in the same clk is sent in the next frame.
REQ-037 SS_N rises after 7 of 16 SCLKs -> frame_err pulse, no rx_valid, next full frame correct.
REQ-038 sresetn pulsed low at bit 9 with SS_N held low -> outputs at reset values, no rx_valid until SS_N rises and a fresh frame completes.
REQ-039 n_bits = 0 and n_bits = 31 -> both treated as 16-bit frames.
